// File: rtl/imem_dual_responder.sv
// imem_dual_responder: 1024x64 dual-instruction fetch memory with a valid/ready word loader.
// Define IMEM_PARITY_EN to store an even-parity bit per 32-bit half and report perr_o.
module imem_dual_responder #(
  parameter int DEPTH = 1024,
  parameter int ADDR_W = 10,
  parameter logic [31:0] NOP = 32'h00000013
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              rd_en_i,
  output logic [63:0]       data_o,
  output logic              busy_o,
  input  logic              ld_start_i,
  input  logic [ADDR_W-1:0] ld_base_i,
  input  logic              ld_valid_i,
  input  logic [31:0]       ld_data_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o
`ifdef IMEM_PARITY_EN
  ,
  output logic              perr_o
`endif
);
`ifdef IMEM_PARITY_EN
  localparam int W = 66;
`else
  localparam int W = 64;
`endif
  typedef enum logic [1:0] {IDLE, LO, HI} state_t;
  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [31:0]       r_lo;
  logic [W-1:0]      r_mem [DEPTH];
  logic              w_hs, w_we;
  logic [63:0]       w_line;
  logic [W-1:0]      w_wdata, w_rd;
  assign w_hs = ld_valid_i & ld_ready_o;
  assign w_we = w_hs & ((r_state == HI) | ld_last_i);
  // A lone final word in LO is padded with a NOP in the upper slot.
  assign w_line = (r_state == HI) ? {ld_data_i, r_lo} : {NOP, ld_data_i};
`ifdef IMEM_PARITY_EN
  assign w_wdata = {^w_line[63:32], ^w_line[31:0], w_line};
`else
  assign w_wdata = w_line;
`endif
  assign w_rd = r_mem[addr_i];
  always_ff @(posedge clock_i)
    if (w_we) r_mem[r_ptr] <= w_wdata;
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_lo       <= '0;
      busy_o     <= 1'b0;
      ld_ready_o <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (ld_start_i) begin
          r_ptr      <= ld_base_i;
          r_state    <= LO;
          busy_o     <= 1'b1;
          ld_ready_o <= 1'b1;
        end
        LO: if (w_hs) begin
          r_lo       <= ld_data_i;
          r_state    <= ld_last_i ? IDLE : HI;
          busy_o     <= !ld_last_i;
          ld_ready_o <= !ld_last_i;
        end
        HI: if (w_hs) begin
          r_ptr      <= r_ptr + 1'b1;
          r_state    <= ld_last_i ? IDLE : LO;
          busy_o     <= !ld_last_i;
          ld_ready_o <= !ld_last_i;
        end
        default: r_state <= IDLE;
      endcase
    end
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) begin
      data_o <= {NOP, NOP};
`ifdef IMEM_PARITY_EN
      perr_o <= 1'b0;
`endif
    end else if (rd_en_i) begin
      data_o <= busy_o ? {NOP, NOP} : w_rd[63:0];
`ifdef IMEM_PARITY_EN
      perr_o <= !busy_o && ((^w_rd[31:0] != w_rd[64]) || (^w_rd[63:32] != w_rd[65]));
`endif
    end
endmodule

// File: tb/tb_imem_dual_responder.sv
// tb_imem_dual_responder: directed plus randomized loads/reads against a line-array reference model.
// With IMEM_PARITY_EN defined, also checks perr_o on a corrupted line.
module tb_imem_dual_responder;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [63:0] NN = {NOP, NOP};
  logic        clk = 0, rst_n = 0, rd_en = 0, ld_start = 0, ld_valid = 0, ld_last = 0;
  logic [9:0]  addr = 0, ld_base = 0;
  logic [31:0] ld_data = 0;
  logic [63:0] data;
  logic        busy, ready;
`ifdef IMEM_PARITY_EN
  logic        perr;
`endif
  int n_cmp = 0, n_err = 0;
  logic [63:0] ref_mem [1024];
  logic [9:0]  written [$];
  logic [31:0] words [$];

  imem_dual_responder dut (
    .clock_i(clk), .reset_n_i(rst_n), .addr_i(addr), .rd_en_i(rd_en), .data_o(data),
    .busy_o(busy), .ld_start_i(ld_start), .ld_base_i(ld_base), .ld_valid_i(ld_valid),
    .ld_data_i(ld_data), .ld_last_i(ld_last), .ld_ready_o(ready)
`ifdef IMEM_PARITY_EN
    , .perr_o(perr)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [9:0] a, input string tag);
    rd_en = 1;
    addr = a;
    step;
    rd_en = 0;
    chk(tag, data, ref_mem[a]);
`ifdef IMEM_PARITY_EN
    chk({tag, "_perr"}, 64'(perr), 64'd0);
`endif
  endtask

  // Loads the current 'words' queue at base; every cycle while busy also fires a
  // masked fetch and an ignored start, and the first cycle pairs start with a stray valid.
  task automatic load(input logic [9:0] base);
    ld_start = 1; ld_base = base; ld_valid = 1; ld_data = $urandom; ld_last = 1; rd_en = 0;
    step;
    ld_start = 0;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_ready", 64'(ready), 64'd1);
    foreach (words[i]) begin
      if ($urandom_range(0, 3) == 0) begin
        ld_valid = 0; rd_en = 1; addr = 10'($urandom);
        step;
        chk("gap_nop", data, NN);
        chk("gap_busy", 64'(busy), 64'd1);
      end
      ld_valid = 1; ld_data = words[i]; ld_last = (i == words.size() - 1);
      rd_en = 1; addr = 10'($urandom);
      ld_start = 1'($urandom_range(0, 1)); ld_base = 10'($urandom);
      step;
      chk("busy_mask", data, NN);
      chk("busy_flag", 64'(busy), ld_last ? 64'd0 : 64'd1);
      chk("ready_flag", 64'(ready), ld_last ? 64'd0 : 64'd1);
    end
    ld_valid = 0; ld_last = 0; ld_start = 0; rd_en = 0;
    step;
    chk("rd_en_hold", data, NN);
    foreach (words[i]) begin
      logic [9:0] a;
      a = base + 10'(i / 2);
      if (i % 2 == 0) begin
        ref_mem[a] = {NOP, words[i]};
        written.push_back(a);
      end else ref_mem[a][63:32] = words[i];
    end
  endtask

  initial begin
    logic [31:0] w0, w1, w2;
    rd_en = 1; addr = 10'($urandom);
    repeat (3) step;
    chk("rst_data", data, NN);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
`ifdef IMEM_PARITY_EN
    chk("rst_perr", 64'(perr), 64'd0);
`endif
    rst_n = 1; rd_en = 0;
    step;

    words = '{32'hAAAA0001, 32'hBBBB0002};
    load(10'd5);
    rd(10'd5, "line5");
    chk("line5_const", data, 64'hBBBB0002_AAAA0001);

    words = '{32'd1, 32'd2, 32'd3};
    load(10'd7);
    rd(10'd7, "line7");
    chk("line7_const", data, 64'h00000002_00000001);
    rd(10'd8, "line8");
    chk("line8_const", data, 64'h00000013_00000003);

    words = {};
    repeat (4) words.push_back($urandom);
    load(10'd1023);
    rd(10'd1023, "wrap_1023");
    chk("wrap_1023_words", data, {words[1], words[0]});
    rd(10'd0, "wrap_0");
    chk("wrap_0_words", data, {words[3], words[2]});

    w0 = $urandom; w1 = $urandom; w2 = $urandom;
    ld_start = 1; ld_base = 10'd200;
    step;
    ld_start = 0; ld_valid = 1;
    ld_data = w0; step;
    ld_data = w1; step;
    ld_data = w2; step;
    ld_valid = 0;
    rst_n = 0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ready", 64'(ready), 64'd0);
    chk("midrst_data", data, NN);
    step;
    rst_n = 1;
    step;
    ref_mem[200] = {w1, w0};
    rd(10'd200, "midrst_pair1");
    rd(10'd5, "survive_line5");

`ifdef IMEM_PARITY_EN
    dut.r_mem[200][5] = ~dut.r_mem[200][5];
    rd_en = 1; addr = 10'd200;
    step;
    chk("perr_flip", 64'(perr), 64'd1);
    addr = 10'd5;
    step;
    chk("perr_clean", 64'(perr), 64'd0);
    rd_en = 0;
    dut.r_mem[200][5] = ~dut.r_mem[200][5];
`endif

    repeat (6) begin
      words = {};
      repeat ($urandom_range(1, 9)) words.push_back($urandom);
      load(10'($urandom));
    end
    repeat (24) rd(written[$urandom_range(0, written.size() - 1)], "rand_read");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
